// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, field widths and operand-fetch FSM state type
// Purpose: common definitions imported by the operand-fetch stage, its interface and sub-module.
// Ports: none (package).
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int OPC_W  = 6;
    localparam int FUN_W  = 6;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_LU_BUBBLE = 1'b1
    } of_state_e;

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode-side, register-bank and EX-side signals of the operand-fetch stage
// Purpose: bundles every non-clock signal of operand_fetch.
// Modports: slave = the operand-fetch block, master = the surrounding pipeline / bench.
interface operand_fetch_if;
    import cpu_pkg::*;

    logic [XLEN-1:0]   in_instr;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic              wb_rw;
    logic [REG_AW-1:0] wb_wa;
    logic [XLEN-1:0]   wb_wd;
    logic              out_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] dst;
    logic              dst_we;
    logic              is_load;
    logic [OPC_W-1:0]  opcode;
    logic [FUN_W-1:0]  funct;

    modport slave (
        input  in_instr, in_valid, flush, rd1, rd2, wb_rw, wb_wa, wb_wd, ex_ready,
        output in_ready, ra1, ra2, out_valid, op_a, op_b, imm_ext, dst, dst_we,
               is_load, opcode, funct
    );

    modport master (
        output in_instr, in_valid, flush, rd1, rd2, wb_rw, wb_wa, wb_wd, ex_ready,
        input  in_ready, ra1, ra2, out_valid, op_a, op_b, imm_ext, dst, dst_we,
               is_load, opcode, funct
    );

endinterface

// File: rtl/imm_ext_unit.sv
// rtl/imm_ext_unit.sv - combinational immediate extension and destination decode
// Purpose: derives imm_ext, dst, dst_we and is_load from a raw instruction word.
// Ports: instr_i (instruction), imm_ext_o, dst_o, dst_we_o, is_load_o.
module imm_ext_unit
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]   instr_i,
    output logic [XLEN-1:0]   imm_ext_o,
    output logic [REG_AW-1:0] dst_o,
    output logic              dst_we_o,
    output logic              is_load_o
);

    logic [OPC_W-1:0] opc;
    logic [15:0]      imm;
    logic             we_raw;
    logic             unused_shamt_funct;

    assign opc = instr_i[31:26];
    assign imm = instr_i[15:0];

    // shamt/funct are consumed elsewhere; only the fields above matter here
    assign unused_shamt_funct = ^instr_i[10:6];

    always_comb begin
        imm_ext_o = {{16{imm[15]}}, imm};
        case (opc)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext_o = {16'h0, imm};
            OP_LUI:                   imm_ext_o = {imm, 16'h0};
            default:                  imm_ext_o = {{16{imm[15]}}, imm};
        endcase
    end

    assign dst_o = (opc == OP_RTYPE) ? instr_i[15:11] : instr_i[20:16];

    // opcodes 0x08..0x0F share the upper bits 3'b001
    assign we_raw    = (opc == OP_RTYPE) || (opc[5:3] == 3'b001) || (opc == OP_LW);
    assign dst_we_o  = we_raw && (dst_o != '0);
    assign is_load_o = (opc == OP_LW);

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand-fetch pipeline register with load-use interlock
// Purpose: reads rs/rt from the register bank, decodes immediate/destination and holds
//          one registered payload for EX; inserts one bubble on a load-use hazard.
// Ports: clk, rst_n (async active-low), bus (operand_fetch_if.slave: decode input
//        handshake, register-bank read/snoop ports, EX-side payload handshake).
// Config: OPERAND_FETCH_WB_BYPASS_EN enables write-through bypass from the wb_* snoop.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);

    of_state_e         state_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   op_a_q, op_b_q, imm_ext_q;
    logic [REG_AW-1:0] dst_q;
    logic              dst_we_q, is_load_q;
    logic [OPC_W-1:0]  opcode_q;
    logic [FUN_W-1:0]  funct_q;

    logic [XLEN-1:0]   op_a_d, op_b_d, imm_ext_d;
    logic [REG_AW-1:0] dst_d;
    logic              dst_we_d, is_load_d;

    logic [REG_AW-1:0] rs, rt;
    logic              hazard;
    logic              in_ready;
    logic              capture;

    assign rs      = bus.in_instr[25:21];
    assign rt      = bus.in_instr[20:16];
    assign bus.ra1 = rs;
    assign bus.ra2 = rt;

    imm_ext_unit u_imm_ext (
        .instr_i   (bus.in_instr),
        .imm_ext_o (imm_ext_d),
        .dst_o     (dst_d),
        .dst_we_o  (dst_we_d),
        .is_load_o (is_load_d)
    );

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // a same-cycle register-bank write wins over the stale read data
    always_comb begin
        op_a_d = bus.rd1;
        op_b_d = bus.rd2;
        if (bus.wb_rw && (bus.wb_wa == rs) && (bus.wb_wa != '0)) op_a_d = bus.wb_wd;
        if (bus.wb_rw && (bus.wb_wa == rt) && (bus.wb_wa != '0)) op_b_d = bus.wb_wd;
        if (rs == '0) op_a_d = '0;
        if (rt == '0) op_b_d = '0;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_rw, bus.wb_wa, bus.wb_wd};

    always_comb begin
        op_a_d = (rs == '0) ? '0 : bus.rd1;
        op_b_d = (rt == '0) ? '0 : bus.rd2;
    end
`endif

    // the held load's result is not available yet for a dependent instruction
    assign hazard = out_valid_q && is_load_q && (dst_q != '0) && bus.in_valid &&
                    ((dst_q == rs) || (dst_q == rt));

    // gated by rst_n so nothing is accepted while reset is asserted
    assign in_ready = rst_n && (!out_valid_q || bus.ex_ready) &&
                      (state_q == ST_RUN) && !hazard;
    assign capture  = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_ext_q   <= '0;
            dst_q       <= '0;
            dst_we_q    <= 1'b0;
            is_load_q   <= 1'b0;
            opcode_q    <= '0;
            funct_q     <= '0;
        end else if (bus.flush) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        if (bus.ex_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_LU_BUBBLE;
                        end
                    end else if (capture) begin
                        out_valid_q <= 1'b1;
                        op_a_q      <= op_a_d;
                        op_b_q      <= op_b_d;
                        imm_ext_q   <= imm_ext_d;
                        dst_q       <= dst_d;
                        dst_we_q    <= dst_we_d;
                        is_load_q   <= is_load_d;
                        opcode_q    <= bus.in_instr[31:26];
                        funct_q     <= bus.in_instr[5:0];
                    end else if (bus.ex_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_LU_BUBBLE: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.imm_ext   = imm_ext_q;
    assign bus.dst       = dst_q;
    assign bus.dst_we    = dst_we_q;
    assign bus.is_load   = is_load_q;
    assign bus.opcode    = opcode_q;
    assign bus.funct     = funct_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] rd_base;
    int          n_pass;
    int          n_total;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // register-bank model: each register holds rd_base + its index
    assign bus.rd1 = rd_base + {27'h0, bus.ra1};
    assign bus.rd2 = rd_base + {27'h0, bus.ra2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rd_base      = 32'h1000;
        rst_n        = 1'b0;
        bus.in_instr = 32'h2008FFFF;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        bus.wb_rw    = 1'b0;
        bus.wb_wa    = 5'd0;
        bus.wb_wd    = 32'h0;

        // reset state
        #2;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_in_ready",  {31'h0, bus.in_ready},  32'h0);
        check("rst_op_a",      bus.op_a,               32'h0);
        check("rst_op_b",      bus.op_b,               32'h0);
        check("rst_imm",       bus.imm_ext,            32'h0);
        check("rst_dst",       {27'h0, bus.dst},       32'h0);
        check("rst_flags",     {30'h0, bus.dst_we, bus.is_load}, 32'h0);
        check("rst_opc_fun",   {20'h0, bus.opcode, bus.funct},   32'h0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // addi $8,$0,-1
        check("addi_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("addi_ra2",      {27'h0, bus.ra2},      32'h8);
        step();
        check("addi_valid",  {31'h0, bus.out_valid}, 32'h1);
        check("addi_imm",    bus.imm_ext,            32'hFFFFFFFF);
        check("addi_dst",    {27'h0, bus.dst},       32'h8);
        check("addi_dst_we", {31'h0, bus.dst_we},    32'h1);
        check("addi_op_a",   bus.op_a,               32'h0);
        check("addi_op_b",   bus.op_b,               32'h1008);
        check("addi_opcode", {26'h0, bus.opcode},    32'h08);

        // ori $3,$2,0x8000 back-to-back
        bus.in_instr = 32'h34438000;
        step();
        check("ori_valid", {31'h0, bus.out_valid}, 32'h1);
        check("ori_imm",   bus.imm_ext,            32'h00008000);
        check("ori_dst",   {27'h0, bus.dst},       32'h3);
        check("ori_op_a",  bus.op_a,               32'h1002);

        // lui $4,0x1234
        bus.in_instr = 32'h3C041234;
        step();
        check("lui_imm",    bus.imm_ext,         32'h12340000);
        check("lui_dst_we", {31'h0, bus.dst_we}, 32'h1);

        // add $0,$1,$2 : write to r0 suppressed
        bus.in_instr = 32'h00220020;
        step();
        check("add0_dst",    {27'h0, bus.dst},    32'h0);
        check("add0_dst_we", {31'h0, bus.dst_we}, 32'h0);
        check("add0_funct",  {26'h0, bus.funct},  32'h20);

        // sw $5,4($6)
        bus.in_instr = 32'hACC50004;
        step();
        check("sw_dst",    {27'h0, bus.dst},     32'h5);
        check("sw_dst_we", {31'h0, bus.dst_we},  32'h0);
        check("sw_imm",    bus.imm_ext,          32'h4);
        check("sw_load",   {31'h0, bus.is_load}, 32'h0);

        // lw $9,0($1) then dependent add $10,$9,$9
        bus.in_instr = 32'h8C290000;
        step();
        check("lw_load",   {31'h0, bus.is_load}, 32'h1);
        check("lw_dst",    {27'h0, bus.dst},     32'h9);
        check("lw_dst_we", {31'h0, bus.dst_we},  32'h1);
        bus.in_instr = 32'h01295020;
        #1;
        check("lu_in_ready_c0", {31'h0, bus.in_ready}, 32'h0);
        step();
        check("lu_bubble",      {31'h0, bus.out_valid}, 32'h0);
        check("lu_in_ready_c1", {31'h0, bus.in_ready},  32'h0);
        step();
        check("lu_in_ready_c2", {31'h0, bus.in_ready},  32'h1);
        step();
        check("lu_add_valid", {31'h0, bus.out_valid}, 32'h1);
        check("lu_add_dst",   {27'h0, bus.dst},       32'hA);
        check("lu_add_op_a",  bus.op_a,               32'h1009);
        check("lu_add_load",  {31'h0, bus.is_load},   32'h0);

        // EX stall for 3 cycles, then flush
        bus.ex_ready = 1'b0;
        bus.in_instr = 32'h3807FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid",    {31'h0, bus.out_valid}, 32'h1);
            check("stall_dst",      {27'h0, bus.dst},       32'hA);
            check("stall_imm",      bus.imm_ext,            32'h00005020);
            check("stall_in_ready", {31'h0, bus.in_ready},  32'h0);
        end
        bus.flush = 1'b1;
        step();
        check("flush_valid", {31'h0, bus.out_valid}, 32'h0);
        bus.flush = 1'b0;

        // write-through bypass on rs=5
        bus.ex_ready = 1'b1;
        rd_base      = 32'h0000000C;
        bus.in_instr = 32'h20A10001;
        bus.wb_rw    = 1'b1;
        bus.wb_wa    = 5'd5;
        bus.wb_wd    = 32'h22;
        step();
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        check("byp_op_a", bus.op_a, 32'h22);
`else
        check("byp_op_a", bus.op_a, 32'h11);
`endif
        check("byp_op_b", bus.op_b, 32'h0D);

        // r0 always zero, even with a snooped write to r0
        bus.in_instr = 32'h20010001;
        bus.wb_wa    = 5'd0;
        step();
        check("r0_op_a",  bus.op_a,               32'h0);
        check("r0_valid", {31'h0, bus.out_valid}, 32'h1);

        // asynchronous reset mid-stream
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid",    {31'h0, bus.out_valid}, 32'h0);
        check("arst_in_ready", {31'h0, bus.in_ready},  32'h0);
        check("arst_op_b",     bus.op_b,               32'h0);
        check("arst_imm",      bus.imm_ext,            32'h0);
        check("arst_dst",      {27'h0, bus.dst},       32'h0);
        check("arst_opcode",   {26'h0, bus.opcode},    32'h0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("post_rst_valid", {31'h0, bus.out_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
